// File: rtl/mult_simd_unpack_acc_if.sv
// Handshake bundle between the DSP multiply stage, the packed accumulator and
// the convolution output stream.
interface mult_simd_unpack_acc_if #(
  parameter int OUT_W = 18
);
  logic [47:0]      p_in;
  logic             p_apVld;
  logic             p_apRdy;
  logic [OUT_W-1:0] lo_out;
  logic [OUT_W-1:0] hi_out;
  logic             out_apVld;
  logic             out_apRdy;
  logic             apIdle;

  // Environment side: feeds products and consumes lane results
  modport master (
    output p_in, p_apVld, out_apRdy,
    input  p_apRdy, lo_out, hi_out, out_apVld, apIdle
  );

  // Accumulator side
  modport slave (
    input  p_in, p_apVld, out_apRdy,
    output p_apRdy, lo_out, hi_out, out_apVld, apIdle
  );
endinterface

// File: rtl/mult_simd_unpack_acc.sv
// Packed two-lane SIMD accumulator. Sums ACC_LEN packed product words
// (a*b)*2^18 + (d*b) and splits the total into signed low and high lane
// results, correcting the borrow that a negative low lane pushes into the
// high lane.
module mult_simd_unpack_acc #(
  parameter int ACC_LEN = 4,
  parameter int OUT_W   = 18
) (
  input  logic                   apClk,
  input  logic                   apRstN,
  input  logic                   apCE,
  mult_simd_unpack_acc_if.slave  bus
);

  localparam logic [2:0] LAST_IDX = 3'(ACC_LEN - 1);

  typedef enum logic {
    ACCUM,
    LAST
  } state_t;

  logic [2:0]       cnt_q, cnt_d;
  logic [47:0]      acc_q, acc_d;
  logic [OUT_W-1:0] lo_q, lo_d;
  logic [OUT_W-1:0] hi_q, hi_d;
  logic             vld_q, vld_d;

  state_t      state;
  logic        p_rdy;
  logic        accept;
  logic        out_xfer;
  logic [47:0] sum;

  // The group position alone decides whether the next word closes the group
  always_comb begin
    state = (cnt_q == LAST_IDX) ? LAST : ACCUM;
  end

  // Handshake qualifiers and the running packed sum including the offered word
  always_comb begin
    p_rdy    = ~((state == LAST) & vld_q & ~bus.out_apRdy);
    accept   = bus.p_apVld & p_rdy & apCE;
    out_xfer = vld_q & bus.out_apRdy & apCE;
    sum      = (cnt_q == 3'd0) ? bus.p_in : (acc_q + bus.p_in);
  end

  // Next-state: accumulate, or close the group and unpack both lanes
  always_comb begin
    cnt_d = cnt_q;
    acc_d = acc_q;
    lo_d  = lo_q;
    hi_d  = hi_q;
    vld_d = vld_q;
    if (out_xfer) begin
      vld_d = 1'b0;
    end
    if (accept) begin
      case (state)
        ACCUM: begin
          acc_d = sum;
          cnt_d = cnt_q + 3'd1;
        end
        LAST: begin
          acc_d = sum;
          lo_d  = sum[OUT_W-1:0];
          hi_d  = sum[2*OUT_W-1:OUT_W] + {{(OUT_W-1){1'b0}}, sum[OUT_W-1]};
          vld_d = 1'b1;
          cnt_d = 3'd0;
        end
        default: begin
          cnt_d = 3'd0;
        end
      endcase
    end
  end

  // State registers with synchronous active-low reset
  always_ff @(posedge apClk) begin
    if (!apRstN) begin
      cnt_q <= 3'd0;
      acc_q <= 48'd0;
      lo_q  <= '0;
      hi_q  <= '0;
      vld_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      acc_q <= acc_d;
      lo_q  <= lo_d;
      hi_q  <= hi_d;
      vld_q <= vld_d;
    end
  end

  assign bus.p_apRdy   = p_rdy;
  assign bus.lo_out    = lo_q;
  assign bus.hi_out    = hi_q;
  assign bus.out_apVld = vld_q;
  assign bus.apIdle    = (cnt_q == 3'd0) & ~vld_q & ~bus.p_apVld;

endmodule
